// File: rtl/reg_file_bit_streamer_pkg.sv
// Shared types and helpers for the activation register-file bit streamer.
package bit_stream_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_e;

  // Width of a plane index for a lane of n bits; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? int'($clog2(n)) : 1;
  endfunction

endpackage

// File: rtl/reg_file_bit_streamer_plane_select.sv
// Picks bit i_idx out of every lane of the active vector; forced to zero when not enabled.
module plane_select
  import bit_stream_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned VEC_LENGTH = 16,
  parameter int unsigned IDX_W      = idx_width(DATA_WIDTH)
) (
  input  logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0] i_vec,
  input  logic [IDX_W-1:0]                      i_idx,
  input  logic                                  i_en,
  output logic [VEC_LENGTH-1:0]                 o_plane
);

  always_comb begin
    o_plane = '0;
    for (int unsigned j = 0; j < VEC_LENGTH; j++) begin
      o_plane[j] = i_en & i_vec[j][i_idx];
    end
  end

endmodule

// File: rtl/reg_file_bit_streamer.sv
// Replays each accepted vector as DATA_WIDTH bit-planes, MSB first, with a one-entry
// pending buffer so back-to-back vectors stream without bubbles.
module reg_file_bit_streamer
  import bit_stream_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = 8,
  parameter  int unsigned VEC_LENGTH = 16,
  localparam int unsigned IDX_W      = idx_width(DATA_WIDTH)
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0] d_in,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  output logic [VEC_LENGTH-1:0]                 plane_out,
  output logic [IDX_W-1:0]                      plane_idx,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic                                  out_last
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

  state_e                                r_state;
  logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0] r_active;
  logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0] r_pend;
  logic                                  r_pend_valid;
  logic [IDX_W-1:0]                      r_idx;

  logic w_act_valid;
  logic w_accept;
  logic w_consume;
  logic w_finish;

  assign w_act_valid = (r_state == STREAM);
  assign w_accept    = in_valid && !r_pend_valid;
  assign w_consume   = w_act_valid && out_ready;
  assign w_finish    = w_consume && (r_idx == '0);

  // Outputs depend only on registers; idle gating keeps them at zero.
  assign in_ready  = !r_pend_valid;
  assign out_valid = w_act_valid;
  assign out_last  = w_act_valid && (r_idx == '0);
  assign plane_idx = w_act_valid ? r_idx : '0;

  plane_select #(
    .DATA_WIDTH (DATA_WIDTH),
    .VEC_LENGTH (VEC_LENGTH),
    .IDX_W      (IDX_W)
  ) u_plane_select (
    .i_vec   (r_active),
    .i_idx   (r_idx),
    .i_en    (w_act_valid),
    .o_plane (plane_out)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_active     <= '0;
      r_pend       <= '0;
      r_pend_valid <= 1'b0;
      r_idx        <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_active <= d_in;
            r_idx    <= LAST_IDX;
            r_state  <= STREAM;
          end
        end
        STREAM: begin
          if (w_finish) begin
            // Pending vector wins; otherwise a same-cycle accept bypasses the buffer.
            if (r_pend_valid) begin
              r_active     <= r_pend;
              r_pend_valid <= 1'b0;
              r_idx        <= LAST_IDX;
            end else if (w_accept) begin
              r_active <= d_in;
              r_idx    <= LAST_IDX;
            end else begin
              r_state <= IDLE;
            end
          end else begin
            if (w_consume) begin
              r_idx <= r_idx - IDX_W'(1);
            end
            if (w_accept) begin
              r_pend       <= d_in;
              r_pend_valid <= 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_file_bit_streamer.sv
// Self-checking bench: constant vector tables, hand sequences and a queue-based reference model.
module tb_reg_file_bit_streamer;

  localparam int DW = 8;
  localparam int VL = 16;

  typedef logic [VL-1:0][DW-1:0] vec_t;

  typedef struct {
    int          idx;
    logic [15:0] plane;
    logic        last;
  } row_t;

  logic            clk;
  logic            reset;
  vec_t            d_in;
  logic            in_valid;
  logic            in_ready;
  logic [VL-1:0]   plane_out;
  logic [2:0]      plane_idx;
  logic            out_valid;
  logic            out_ready;
  logic            out_last;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: queue of stored vectors (head is streaming) and head plane position.
  vec_t mq[$];
  int   mpos = DW - 1;

  reg_file_bit_streamer dut (
    .clk       (clk),
    .reset     (reset),
    .d_in      (d_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .plane_out (plane_out),
    .plane_idx (plane_idx),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [VL-1:0] bitplane(input vec_t v, input int k);
    logic [VL-1:0] p;
    for (int j = 0; j < VL; j++) p[j] = v[j][k];
    return p;
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    for (int j = 0; j < VL; j++) v[j] = 8'($urandom);
    return v;
  endfunction

  function automatic vec_t fill_vec(input logic [7:0] b);
    vec_t v;
    for (int j = 0; j < VL; j++) v[j] = b;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    mpos = DW - 1;
  endtask

  task automatic model_step(input logic iv, input vec_t v, input logic ordy);
    bit acc, con;
    acc = iv && (mq.size() < 2);
    con = (mq.size() > 0) && ordy;
    if (con) begin
      if (mpos == 0) begin
        void'(mq.pop_front());
        mpos = DW - 1;
      end else begin
        mpos--;
      end
    end
    if (acc) mq.push_back(v);
  endtask

  task automatic check_model(input string tag);
    logic        ev, el;
    logic [15:0] ep;
    logic [2:0]  ei;
    ev = (mq.size() > 0);
    ep = ev ? bitplane(mq[0], mpos) : '0;
    ei = ev ? 3'(mpos) : '0;
    el = ev && (mpos == 0);
    chk({tag, ".in_ready"},  32'(in_ready),  32'(mq.size() < 2));
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(ev));
    chk({tag, ".plane_out"}, 32'(plane_out), 32'(ep));
    chk({tag, ".plane_idx"}, 32'(plane_idx), 32'(ei));
    chk({tag, ".out_last"},  32'(out_last),  32'(el));
  endtask

  // Drive one cycle from a negedge and advance the model to match the coming posedge.
  task automatic cyc(input logic iv, input vec_t v, input logic ordy);
    in_valid  = iv;
    d_in      = v;
    out_ready = ordy;
    model_step(iv, v, ordy);
    @(negedge clk);
  endtask

  initial begin
    row_t tbl[8];
    vec_t va, vb, vc, vd, ve, vf, vj;
    logic [15:0] held;

    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0; d_in = '0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst.in_ready",  32'(in_ready),  32'd1);
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.out_last",  32'(out_last),  32'd0);
    chk("rst.plane_out", 32'(plane_out), 32'd0);
    chk("rst.plane_idx", 32'(plane_idx), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // Single vector, lane j = j: expected planes from the binary patterns of 0..15.
    for (int j = 0; j < VL; j++) vj[j] = 8'(j);
    tbl[0] = '{7, 16'h0000, 1'b0};
    tbl[1] = '{6, 16'h0000, 1'b0};
    tbl[2] = '{5, 16'h0000, 1'b0};
    tbl[3] = '{4, 16'h0000, 1'b0};
    tbl[4] = '{3, 16'hFF00, 1'b0};
    tbl[5] = '{2, 16'hF0F0, 1'b0};
    tbl[6] = '{1, 16'hCCCC, 1'b0};
    tbl[7] = '{0, 16'hAAAA, 1'b1};
    cyc(1'b1, vj, 1'b1);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("single[%0d].valid", k), 32'(out_valid), 32'd1);
      chk($sformatf("single[%0d].idx", k),   32'(plane_idx), 32'(tbl[k].idx));
      chk($sformatf("single[%0d].plane", k), 32'(plane_out), 32'(tbl[k].plane));
      chk($sformatf("single[%0d].last", k),  32'(out_last),  32'(tbl[k].last));
      cyc(1'b0, '0, 1'b1);
    end
    chk("single.done.valid", 32'(out_valid), 32'd0);
    chk("single.done.plane", 32'(plane_out), 32'd0);

    // Back-to-back A (all ones) then B (all zeros), no gap.
    va = fill_vec(8'hFF);
    vb = fill_vec(8'h00);
    cyc(1'b1, va, 1'b1);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("b2b[%0d].valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("b2b[%0d].plane", i), 32'(plane_out), (i < 8) ? 32'hFFFF : 32'h0);
      chk($sformatf("b2b[%0d].idx", i),   32'(plane_idx), 32'(7 - (i % 8)));
      chk($sformatf("b2b[%0d].ready", i), 32'(in_ready),  32'((i == 0) || (i >= 8)));
      if (i == 0) cyc(1'b1, vb, 1'b1);
      else        cyc(1'b0, '0, 1'b1);
    end
    chk("b2b.done.valid", 32'(out_valid), 32'd0);

    // Backpressure at idx 5 for three cycles.
    vc = rand_vec();
    cyc(1'b1, vc, 1'b1);
    cyc(1'b0, '0, 1'b1);
    cyc(1'b0, '0, 1'b1);
    chk("bp.idx5", 32'(plane_idx), 32'd5);
    held = plane_out;
    chk("bp.plane5", 32'(held), 32'(bitplane(vc, 5)));
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, '0, 1'b0);
      chk($sformatf("bp.stall[%0d].idx", i),   32'(plane_idx), 32'd5);
      chk($sformatf("bp.stall[%0d].plane", i), 32'(plane_out), 32'(held));
      chk($sformatf("bp.stall[%0d].valid", i), 32'(out_valid), 32'd1);
    end
    cyc(1'b0, '0, 1'b1);
    chk("bp.resume.idx", 32'(plane_idx), 32'd4);
    repeat (5) cyc(1'b0, '0, 1'b1);
    chk("bp.done.valid", 32'(out_valid), 32'd0);

    // Bypass: new vector offered exactly on the finish cycle with pending empty.
    vd = rand_vec();
    ve = rand_vec();
    cyc(1'b1, vd, 1'b1);
    repeat (7) cyc(1'b0, '0, 1'b1);
    chk("byp.last", 32'(out_last), 32'd1);
    chk("byp.ready", 32'(in_ready), 32'd1);
    cyc(1'b1, ve, 1'b1);
    chk("byp.valid", 32'(out_valid), 32'd1);
    chk("byp.idx",   32'(plane_idx), 32'd7);
    chk("byp.plane", 32'(plane_out), 32'(bitplane(ve, 7)));
    repeat (8) cyc(1'b0, '0, 1'b1);
    chk("byp.done.valid", 32'(out_valid), 32'd0);

    // Reset asserted mid-stream at idx 3.
    vf = rand_vec();
    cyc(1'b1, vf, 1'b1);
    repeat (4) cyc(1'b0, '0, 1'b1);
    chk("mrst.pre.idx", 32'(plane_idx), 32'd3);
    #1 reset = 1'b0;
    #1;
    chk("mrst.valid", 32'(out_valid), 32'd0);
    chk("mrst.ready", 32'(in_ready),  32'd1);
    chk("mrst.idx",   32'(plane_idx), 32'd0);
    chk("mrst.plane", 32'(plane_out), 32'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, '0, 1'b1);
      chk($sformatf("mrst.after[%0d].valid", i), 32'(out_valid), 32'd0);
    end
    cyc(1'b1, vf, 1'b1);
    chk("mrst.new.idx", 32'(plane_idx), 32'd7);
    check_model("mrst.new");

    // Randomized traffic against the queue model.
    for (int i = 0; i < 600; i++) begin
      logic iv, ordy;
      iv   = ($urandom % 3) != 0;
      ordy = ($urandom % 4) != 0;
      cyc(iv, rand_vec(), ordy);
      check_model($sformatf("rnd[%0d]", i));
    end
    for (int i = 0; i < 20; i++) begin
      cyc(1'b0, '0, 1'b1);
      check_model($sformatf("drain[%0d]", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_file_bit_streamer.md
# reg_file_bit_streamer

Read side of the activation register file. The block accepts whole DATA_WIDTH-bit vectors of VEC_LENGTH lanes from the SRAM-fed register path. It replays each vector to the bit-serial PE array as DATA_WIDTH bit-planes, MSB plane first, over a valid/ready handshake. A one-entry pending buffer lets the next vector load while the current one streams, so back-to-back vectors produce no bubbles.

## Interface
- DATA_WIDTH, 8, bits per lane; also the number of planes per vector.
- VEC_LENGTH, 16, number of lanes.
- IDX_W, $clog2(DATA_WIDTH), width of plane_idx (derived).
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low; 0 clears all state immediately.
- d_in  in  [DATA_WIDTH-1:0] x [VEC_LENGTH-1:0]  vector to stream.
- in_valid  in  1  d_in is valid.
- in_ready  out  1  block can accept d_in this cycle.
- plane_out  out  [VEC_LENGTH-1:0]  current bit-plane; lane j = active[j][plane_idx].
- plane_idx  out  IDX_W  bit position of plane_out.
- out_valid  out  1  plane_out is valid.
- out_ready  in  1  PE array consumes plane this cycle.
- out_last  out  1  plane_out is plane 0, the last plane of the vector.

## Operation
- State:
  - active vector register plus act_valid.
  - pending vector register plus pend_valid.
  - down-counter idx.
- FSM states:
  - IDLE: act_valid=0.
  - STREAM: act_valid=1.
- Definitions:
  - in_ready = !pend_valid.
  - out_valid = act_valid.
  - out_last = act_valid && idx==0.
- Accept = in_valid && in_ready. Consume = out_valid && out_ready. Finish = consume && out_last.
- Accept with act_valid=0: d_in goes to active, idx <= DATA_WIDTH-1, STREAM.
- Accept with act_valid=1 and no finish: d_in goes to pending.
- Consume and not last: idx <= idx-1. The active data is unchanged.
- Finish:
  - If pend_valid: pending goes to active, pend_valid <= 0, idx <= DATA_WIDTH-1, stay in STREAM.
  - Else if accept in the same cycle: d_in goes directly to active, idx <= DATA_WIDTH-1, stay in STREAM (bypass, no bubble).
  - Else: act_valid <= 0, go to IDLE.
- Finish with pend_valid=1: in_ready is already 0, so no accept is possible that cycle. The pending slot frees on the following cycle.
- out_valid low: plane_out, plane_idx and out_last are held at 0.
- Planes are raw bits with no sign or zero-skip handling. Arithmetic weighting is the PE array's job.

## Timing
- Reset values:
  - in_ready=1, out_valid=0, out_last=0, plane_out=0, plane_idx=0.
  - act_valid=0, pend_valid=0, idx=0, FSM=IDLE.
- Latency: vector accepted at edge N gives plane DATA_WIDTH-1 valid after edge N.
- Throughput: one plane per cycle while out_ready=1. A vector occupies exactly DATA_WIDTH consume cycles.
- Every output is register-derived. No combinational path from in_valid or out_ready to any output.
- Handshake rules:
  - While out_valid=1 && out_ready=0, plane_out, plane_idx and out_last stay stable.
  - in_ready never depends on in_valid.
- Reset asserted mid-stream: the vector is discarded and outputs go to reset values asynchronously. The first valid plane after deassertion belongs to a newly accepted vector.

## Structure
- Package bit_stream_pkg holds:
  - state enum {IDLE, STREAM}.
  - plane-index width helper function.
- Sub-module plane_select (combinational) takes the active vector and idx and produces plane_out. It has no state.
- Top module holds the FSM, counter, and both buffers.

## Test plan
- Single vector:
  - Stimulus: lane j = j (0..15) with out_ready=1.
  - Expected: 8 planes, plane_idx 7..0, plane 0 = 16'hAAAA, plane 1 = 16'hCCCC, plane 7 = 0, out_last only on idx 0, then out_valid=0.
- Back-to-back vectors with in_valid held:
  - Stimulus: vectors A (all 8'hFF) and B (all 8'h00).
  - Expected: 16 consecutive valid cycles: 8 planes of 16'hFFFF then 8 of 16'h0000. in_ready=0 from the cycle B is buffered until A finishes.
- Backpressure:
  - Stimulus: out_ready=0 for 3 cycles at idx 5.
  - Expected: plane_out and plane_idx=5 stay stable, idx does not decrement, streaming resumes at 5.
- Bypass:
  - Stimulus: pending empty, in_valid asserted exactly on the finish cycle.
  - Expected: next cycle shows the new vector at idx 7 with no out_valid gap.
- Reset mid-stream:
  - Stimulus: reset=0 at idx 3.
  - Expected: out_valid=0 and in_ready=1 immediately; after release, out_valid stays 0 until a new accept.
